// File: rtl/mult_acc_if.sv
// Operand/product/frame-sum bundle between mult_acc, the array multiplier and its neighbours.
// Latency: none, because this is wiring only.
// Backpressure: in_valid/in_ready on the operand side and out_valid/out_ready on the sum side.
interface mult_acc_if #(
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [7:0]       mult_a;
    logic [7:0]       mult_b;
    logic [7:0]       mult_x;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    // The block's own view.
    modport slave (
        input  in_valid, in_a, in_b, mult_x, out_ready,
        output in_ready, mult_a, mult_b, out_valid, out_sum, out_ovf
    );

    // The surrounding environment: upstream, multiplier and downstream.
    modport master (
        output in_valid, in_a, in_b, mult_x, out_ready,
        input  in_ready, mult_a, mult_b, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/mult_acc.sv
// Dot-product stage that registers 8-bit multiplier products and sums them over FRAME_LEN pairs.
// Latency: the sum is valid one cycle after the last pair of a frame is accepted.
// Backpressure: in_ready drops once a frame is full and returns after the sum is taken. Macro MULT_ACC_SAT_EN makes the sum saturate instead of wrapping.
module mult_acc #(
    parameter int FRAME_LEN = 4,
    parameter int ACC_W     = 16
) (
    input logic      clk,
    input logic      rst,
    input logic      clr,
    mult_acc_if.slave bus
);
    localparam int             CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             p_vld_q, p_vld_d;
    logic             p_last_q, p_last_d;
    logic [7:0]       p_reg_q, p_reg_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    logic             in_rdy;
    logic             out_vld;
    logic             accept;
    logic             xfer;
    logic [ACC_W:0]   sum_ext;

    // The multiplier sits outside this block and operates directly on the live operands.
    assign bus.mult_a = bus.in_a;
    assign bus.mult_b = bus.in_b;

    assign in_rdy  = (state_q == ST_ACC) && (cnt_q < CNT_FULL);
    assign out_vld = (state_q == ST_OUT);
    assign accept  = bus.in_valid & in_rdy;
    assign xfer    = out_vld & bus.out_ready;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_sum   = out_vld ? acc_q : '0;
    assign bus.out_ovf   = out_vld & ovf_q;

    // One extra bit holds the carry-out of each product add.
    assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(p_reg_q);

    // Next state: product capture, accumulate, frame hand-off, and clear (which wins over everything).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_vld_d  = 1'b0;
        p_last_d = p_last_q;
        p_reg_d  = p_reg_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;

        if (accept) begin
            p_reg_d  = bus.mult_x;
            p_vld_d  = 1'b1;
            p_last_d = (cnt_q == CNT_LAST);
            cnt_d    = cnt_q + CNT_W'(1);
        end

        if (p_vld_q) begin
`ifdef MULT_ACC_SAT_EN
            // Once the frame has overflowed, it stays pinned at full scale.
            acc_d = (sum_ext[ACC_W] || ovf_q) ? '1 : sum_ext[ACC_W-1:0];
`else
            acc_d = sum_ext[ACC_W-1:0];
`endif
            ovf_d = ovf_q | sum_ext[ACC_W];
        end

        case (state_q)
            ST_ACC: begin
                if (p_vld_q && p_last_q) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (xfer) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase

        if (clr) begin
            state_d  = ST_ACC;
            cnt_d    = '0;
            p_vld_d  = 1'b0;
            p_last_d = 1'b0;
            p_reg_d  = '0;
            acc_d    = '0;
            ovf_d    = 1'b0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_ACC;
            cnt_q    <= '0;
            p_vld_q  <= 1'b0;
            p_last_q <= 1'b0;
            p_reg_q  <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_vld_q  <= p_vld_d;
            p_last_q <= p_last_d;
            p_reg_q  <= p_reg_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: doc/mult_acc.md
Name: mult_acc

Overview:
- Sequential wrapper directly around the 8-bit combinational array multiplier (ports a, b, x).
- Feeds the multiplier its operands from a valid/ready stream and registers each 8-bit product.
- Accumulates the products over a fixed frame of FRAME_LEN operand pairs.
- Presents each frame sum on a valid/ready output; serves as the dot-product stage behind the multiplier.

Parameters:
- FRAME_LEN, 4, operand pairs per frame; legal range 1..255.
- ACC_W, 16, accumulator and out_sum width; legal range 8..32.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous abort/clear of the current frame.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  8  operand A.
- in_b  in  8  operand B.
- mult_a  out  8  to multiplier input a; equals in_a (combinational).
- mult_b  out  8  to multiplier input b; equals in_b (combinational).
- mult_x  in  8  from multiplier output x; low 8 bits of a*b.
- out_valid  out  1  frame sum valid.
- out_ready  in  1  downstream accepts the sum.
- out_sum  out  ACC_W  frame sum.
- out_ovf  out  1  overflow flag for the presented frame.

Behaviour:
- Reset (async, rst=1): state=ACC, cnt=0, p_vld=0, p_reg=0, acc=0, ovf=0. Outputs: in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
- Handshakes:
  - Accept occurs on an edge where in_valid&in_ready=1.
  - Output transfer occurs on an edge where out_valid&out_ready=1.
- Stage 1: on accept, p_reg<=mult_x, p_vld<=1, p_last<=(cnt==FRAME_LEN-1), cnt<=cnt+1. With no accept, p_vld<=0.
- Stage 2: when p_vld=1, acc<=acc+zero-extended p_reg, computed in ACC_W+1 bits; ovf<=ovf|carry-out.
- in_ready=(state==ACC)&&(cnt<FRAME_LEN). Deasserts after the FRAME_LEN-th accept and stays low until the output transfer.
- States:
  - ACC: collecting products. When p_vld&p_last, the final add completes and state moves to OUT on the same edge.
  - OUT: out_valid=1; out_sum=acc and out_ovf=ovf, both held stable while out_ready=0.
  - On output transfer: acc=0, ovf=0, cnt=0, state=ACC. in_ready=1 in the following cycle.
- Latency: last pair accepted at edge n -> out_valid=1 after edge n+1. Back-to-back accepts are allowed, one per cycle.
- FRAME_LEN=1: each accepted pair produces one output.
- Arithmetic: only the 8-bit truncated product is used (mult_x). Accumulation is unsigned.
- clr=1 at an edge: same effect as reset except it is synchronous. It overrides accept and output transfer in that cycle; a frame in OUT is discarded.
- in_valid while in_ready=0: ignored. Upstream holds data; no implicit capture.
- rst asserted mid-frame or mid-OUT: immediate return to reset state; the partial sum is lost.

Optional Feature:
- Macro: MULT_ACC_SAT_EN.
- Defined: on carry-out, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the frame; out_ovf=1.
- Undefined: acc wraps modulo 2^ACC_W; out_ovf=1 if any wrap occurred in the frame.

Test Plan:
- Basic frame: FRAME_LEN=4, ACC_W=16; pairs (3,5),(2,7),(10,10),(1,1) on consecutive cycles, out_ready=1 -> out_valid 1 cycle after the 4th accept, out_sum=130, out_ovf=0, in_ready high again next cycle.
- Truncation: pairs (16,16),(255,255),(0,9),(1,200) -> products 0,1,0,200; out_sum=201.
- Backpressure: complete a frame with out_ready=0 for 5 cycles -> out_sum stable, in_ready=0, and in_valid pulses ignored. out_ready=1 -> single transfer, then a new frame accepted.
- Overflow: ACC_W=8, FRAME_LEN=2; pairs (200,1),(200,1) -> out_sum=144, out_ovf=1. With MULT_ACC_SAT_EN: out_sum=255, out_ovf=1.
- Abort: clr=1 after 2 accepts, then the basic-frame stimulus -> out_sum=130. Repeat with rst pulsed asynchronously mid-frame -> all outputs 0 immediately, then next frame correct.
- Stall gaps: FRAME_LEN=3 with in_valid idle 2 cycles between pairs (4,4),(5,5),(6,6) -> out_sum=77.
